bcd_display_scanner: RTL
========================

Name: bcd_display_scanner

Overview:
- Upstream feeder for the 7-segment decoder (4-bit BCD in, 7 segments out).
- Accepts a binary value over a valid/ready handshake and converts it to DIGITS BCD digits with a sequential double-dabble algorithm.
- Time-multiplexes the digits onto one 4-bit `number` bus and drives one-hot active-low anode enables, so a single decoder instance serves a multi-digit display.

Parameters:
- DIGITS, 4: number of display digits.
- BIN_W, 14: width of the binary input; 14 covers 9999.
- REFRESH_DIV, 100000: clk cycles each digit stays selected, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_value  input  BIN_W  binary value to display.
- in_valid  input  1  in_value is valid.
- in_ready  output  1  block can accept a value.
- number  output  4  BCD digit of the currently selected position, to the decoder.
- anodes  output  DIGITS  active-low digit enables, exactly one bit low.
- overflow  output  1  last accepted value exceeded 10^DIGITS-1.
- busy  output  1  conversion in progress.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low. All state is on clk rising edge and cleared immediately when rst_n=0.
- Reset values:
  - FSM = IDLE; in_ready=1; busy=0; overflow=0.
  - All display digits = 0; scan index = 0; refresh counter = 0.
  - anodes = all ones except bit0 low (4'b1110); number = 0.
- FSM states:
  - IDLE: in_ready=1. When in_valid&&in_ready, latch in_value into the shift register, clear the BCD accumulator, go to CONVERT.
  - CONVERT: busy=1, in_ready=0. Exactly BIN_W cycles. Each cycle, add 3 to every BCD nibble >=5, then shift left one bit, with the binary MSB entering the BCD LSB. After BIN_W cycles go to COMMIT.
  - COMMIT: one cycle, busy=1, in_ready=0. Copy the accumulator to the display register, or all 9s if overflow. Return to IDLE.
- Latency:
  - Display register updates on the edge ending COMMIT, BIN_W+1 cycles after the accepting edge.
  - in_ready is low for exactly BIN_W+1 cycles after an accept.
- Overflow:
  - Compared at accept: in_value > 10^DIGITS-1 (constant computed from DIGITS).
  - overflow is registered at accept and held until the next accept.
  - On overflow, display shows every digit = 9.
- Handshake:
  - in_valid while in_ready=0 is ignored; upstream holds the value until a cycle with in_ready=1.
  - Back-to-back accepts are spaced BIN_W+2 cycles apart.
- Scanner (independent of FSM):
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, scan index increments; index DIGITS-1 wraps to 0.
  - anodes = ~(1<<index); number = display digit[index]; digit0 is least significant.
  - The scan is not restarted by a display update. The new digits appear on the current position in the cycle after COMMIT.
- Leading zeros are shown, not blanked. number never carries a code above 9.
- Reset mid-conversion: conversion aborts, all outputs take reset values asynchronously, and the pending value is lost.

Decomposition:
- Package display_pkg:
  - DIGIT_W=4.
  - typedef bcd_digit_t (logic [3:0]).
  - typedef bcd_vec_t (array of DIGITS bcd_digit_t).
  - enum scan_state_t {IDLE, CONVERT, COMMIT}.
- One sub-module, bin2bcd_seq: the double-dabble datapath with shift register, nibble add-3 and cycle counter. It takes start and value and returns done and bcd_vec.
- The top holds the FSM, overflow compare, display register and scanner.

Test Plan:
- Reset (REFRESH_DIV=4 for all tests): after rst_n low then high, anodes=4'b1110, number=0, in_ready=1, overflow=0.
- Basic conversion: in_value=1234 accepted -> in_ready low for 15 cycles. Scan then shows number 4,3,2,1 with anodes 1110,1101,1011,0111, each held 4 cycles, and repeats.
- Boundaries:
  - 9999 -> digits 9,9,9,9 with overflow=0.
  - 0 -> 0,0,0,0.
  - 10000 -> overflow=1, digits all 9.
  - A following 5 -> overflow=0, digits 5,0,0,0.
- Handshake: 42 accepted; in_valid held high with 77 during conversion -> 77 ignored until in_ready returns. 77 is accepted on that cycle and the display ends at 7,7,0,0.
- Reset mid-operation: rst_n pulled low 5 cycles into CONVERT of 8888 -> outputs immediately at reset values. After release, display stays 0 and in_ready=1.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and helpers for the BCD display scanner.
package display_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned DISP_DIGITS = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;
    typedef bcd_digit_t [DISP_DIGITS-1:0] bcd_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } scan_state_t;

    // Double-dabble correction: a nibble of 5 or more would exceed 9 after doubling.
    function automatic bcd_digit_t add3_if_ge5(input bcd_digit_t d);
        return (d >= 4'd5) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/correct step per clock, BIN_W steps.
module bin2bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          value,
    output logic                      done_c,
    output logic [DIGITS*DIGIT_W-1:0] bcd_vec
);

    localparam int unsigned BCD_W = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] sr_q,  sr_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [BCD_W-1:0] adj_c;

    // High when the step taken this cycle is the final one.
    assign done_c  = active_q && (cnt_q == CNT_W'(BIN_W - 1));
    assign bcd_vec = bcd_q;

    // Per-nibble add-3 correction ahead of the shift.
    always_comb begin
        adj_c = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            adj_c[i*DIGIT_W +: DIGIT_W] = add3_if_ge5(bcd_q[i*DIGIT_W +: DIGIT_W]);
        end
    end

    // Load on start, otherwise shift binary MSB into the corrected accumulator.
    always_comb begin
        sr_d     = sr_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (start) begin
            sr_d     = value;
            bcd_d    = '0;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            bcd_d = {adj_c[BCD_W-2:0], sr_q[BIN_W-1]};
            sr_d  = {sr_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
            if (done_c) begin
                active_d = 1'b0;
            end
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q     <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Binary-to-BCD front end and digit multiplexer for a shared 7-segment decoder.
module bcd_display_scanner
    import display_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned BIN_W       = 14,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  in_value,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [3:0]        number,
    output logic [DIGITS-1:0] anodes,
    output logic              overflow,
    output logic              busy
);

    localparam int unsigned MAX_VAL = (10 ** DIGITS) - 1;
    localparam int unsigned REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_state_t                 state_q, state_d;
    logic                        in_ready_q, in_ready_d;
    logic                        busy_q, busy_d;
    logic                        overflow_q, overflow_d;
    bcd_digit_t [DIGITS-1:0]     disp_q, disp_d;
    logic [REF_W-1:0]            ref_q, ref_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DIGITS-1:0]           anodes_q, anodes_d;
    bcd_digit_t                  number_q, number_d;

    logic                        start_c;
    logic                        conv_done_c;
    logic [DIGITS*DIGIT_W-1:0]   conv_bcd_c;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .value   (in_value),
        .done_c  (conv_done_c),
        .bcd_vec (conv_bcd_c)
    );

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;
    assign anodes   = anodes_q;
    assign number   = number_q;

    // Control FSM: accept, convert, then commit result (or all 9s) to the display.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        disp_d     = disp_q;
        start_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    start_c    = 1'b1;
                    overflow_d = (32'(in_value) > MAX_VAL);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done_c) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    disp_d[i] = overflow_q ? bcd_digit_t'(9)
                                           : conv_bcd_c[i*DIGIT_W +: DIGIT_W];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // Free-running digit scan; picks up display changes without restarting.
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        idx_d = idx_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        anodes_d = ~(DIGITS'(1) << idx_d);
        number_d = disp_d[idx_d];
    end

    // All state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
            ref_q      <= '0;
            idx_q      <= '0;
            anodes_q   <= ~DIGITS'(1);
            number_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            disp_q     <= disp_d;
            ref_q      <= ref_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            number_q   <= number_d;
        end
    end

endmodule
